// File: rtl/sub_sm_dispatcher.sv
// Command dispatcher: maps a host command word onto one sub-state-machine and runs
// its Enable/Done handshake under a per-phase timeout, with abort and error reporting.
module sub_sm_dispatcher #(
    parameter logic [15:0] CMD_BASE = 16'h0001,
    parameter int unsigned NUM_SUB  = 4,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               CmdValid,
    input  logic [15:0]        CmdWord,
    input  logic               Abort,
    output logic               CmdReady,
    output logic [15:0]        SysState,
    output logic [NUM_SUB-1:0] SubEnable,
    input  logic [NUM_SUB-1:0] SubDone,
    output logic               Busy,
    output logic               CmdDone,
    output logic               CmdErr,
    output logic [1:0]         ErrCode
);
    localparam int unsigned CNT_W = 16;
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ENABLE, S_RELEASE, S_REPORT} state_t;

    state_t             state_q;
    logic               ready_q;
    logic [15:0]        sys_q;
    logic [NUM_SUB-1:0] sub_en_q;
    logic [NUM_SUB-1:0] sel_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [15:0]        idx_c;
    logic               legal_c;
    logic [NUM_SUB-1:0] onehot_c;
    logic               done_hit_c;
    logic               tmo_c;

    // Wrap-around below CMD_BASE yields a huge idx and so falls out as illegal.
    assign idx_c      = CmdWord - CMD_BASE;
    assign legal_c    = idx_c < 16'(NUM_SUB);
    assign onehot_c   = NUM_SUB'(1) << idx_c[2:0];
    assign done_hit_c = |(SubDone & sel_q);
    assign tmo_c      = (cnt_q == (TIMEOUT - 16'd1));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            sys_q    <= 16'h0000;
            sub_en_q <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CmdValid && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (legal_c) begin
                            state_q  <= S_ENABLE;
                            sys_q    <= CmdWord;
                            sel_q    <= onehot_c;
                            sub_en_q <= onehot_c;
                        end else begin
                            state_q <= S_REPORT;
                            sel_q   <= '0;
                            err_q   <= 1'b1;
                            code_q  <= ERR_ILLEGAL;
                        end
                    end
                end
                // Priority in both handshake phases: abort, then done condition, then timeout.
                S_ENABLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (Abort) begin
                        state_q  <= S_REPORT;
                        sub_en_q <= '0;
                        err_q    <= 1'b1;
                        code_q   <= ERR_ABORT;
                    end else if (done_hit_c) begin
                        state_q  <= S_RELEASE;
                        sub_en_q <= '0;
                        cnt_q    <= '0;
                    end else if (tmo_c) begin
                        state_q  <= S_REPORT;
                        sub_en_q <= '0;
                        err_q    <= 1'b1;
                        code_q   <= ERR_TIMEOUT;
                    end
                end
                S_RELEASE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (Abort) begin
                        state_q <= S_REPORT;
                        err_q   <= 1'b1;
                        code_q  <= ERR_ABORT;
                    end else if (!done_hit_c) begin
                        state_q <= S_REPORT;
                        done_q  <= 1'b1;
                        code_q  <= ERR_OK;
                    end else if (tmo_c) begin
                        state_q <= S_REPORT;
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                    end
                end
                S_REPORT: begin
                    state_q <= S_IDLE;
                    sys_q   <= 16'h0000;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    sel_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CmdReady  = ready_q;
    assign SysState  = sys_q;
    assign SubEnable = sub_en_q;
    assign Busy      = busy_q;
    assign CmdDone   = done_q;
    assign CmdErr    = err_q;
    assign ErrCode   = code_q;

endmodule
